// File: rtl/xbar_ahb_pkg.sv
// Shared AHB crossbar types: transfer encodings, ingress FSM states and the address-region descriptor.
package xbar_ahb_pkg;

  localparam int PKG_ADDR_WIDTH = 32;
  localparam int PKG_ID_WIDTH   = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ingress_state_e;

  typedef struct packed {
    logic [PKG_ADDR_WIDTH-1:0] base;
    logic [PKG_ADDR_WIDTH-1:0] mask;
    logic [PKG_ID_WIDTH-1:0]   cid;
  } region_t;

  function automatic logic region_hit(input region_t r, input logic [PKG_ADDR_WIDTH-1:0] addr);
    return (addr & r.mask) == (r.base & r.mask);
  endfunction

endpackage

// File: rtl/xbar_ahb_addr_dec.sv
// Combinational priority address decoder: the lowest-index matching region supplies the column tag.
module xbar_ahb_addr_dec
  import xbar_ahb_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter logic [NUM_REGIONS-1:0][PKG_ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS-1:0][PKG_ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter logic [NUM_REGIONS-1:0][PKG_ID_WIDTH-1:0]   REGION_CID  = '0
) (
  input  logic [PKG_ADDR_WIDTH-1:0] addr_i,
  output logic                      hit_o,
  output logic [PKG_ID_WIDTH-1:0]   cid_o
);

  region_t region;

  // Scan from the highest index down so the lowest-index hit is the last one written.
  always_comb begin
    hit_o  = 1'b0;
    cid_o  = '0;
    region = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      region = '{base: REGION_BASE[i], mask: REGION_MASK[i], cid: REGION_CID[i]};
      if (region_hit(region, addr_i)) begin
        hit_o = 1'b1;
        cid_o = region.cid;
      end
    end
  end

endmodule

// File: rtl/xbar_ahb_ingress.sv
// Manager-side AHB crossbar ingress: decodes a column tag and re-times one transfer toward the node grid.
// Define XBAR_AHB_DECERR_EN to terminate unmapped accesses locally with a two-cycle ERROR.
module xbar_ahb_ingress
  import xbar_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int XBAR_ID_WIDTH = 2,
  parameter int NUM_REGIONS   = 4,
  parameter logic [XBAR_ID_WIDTH-1:0] ROW_ID = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0]    REGION_BASE = '0,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0]    REGION_MASK = '0,
  parameter logic [NUM_REGIONS-1:0][XBAR_ID_WIDTH-1:0] REGION_CID  = '0,
  parameter logic [XBAR_ID_WIDTH-1:0] DEFAULT_CID = '0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     hclk_i,
  input  logic                     hrst_i,
  input  logic [ADDR_WIDTH-1:0]    haddr_i,
  input  logic [1:0]               htrans_i,
  input  logic                     hwrite_i,
  input  logic [2:0]               hsize_i,
  input  logic                     hsel_i,
  input  logic [DATA_WIDTH-1:0]    hwdata_i,
  input  logic [STRB_WIDTH-1:0]    hwstrb_i,
  output logic [DATA_WIDTH-1:0]    hrdata_o,
  output logic                     hreadyout_o,
  output logic                     hresp_o,
  output logic [XBAR_ID_WIDTH-1:0] rid_o,
  output logic [XBAR_ID_WIDTH-1:0] cid_o,
  output logic [ADDR_WIDTH-1:0]    haddr_o,
  output logic [1:0]               htrans_o,
  output logic                     hwrite_o,
  output logic [2:0]               hsize_o,
  output logic                     hsel_o,
  output logic [DATA_WIDTH-1:0]    hwdata_o,
  output logic [STRB_WIDTH-1:0]    hwstrb_o,
  input  logic [DATA_WIDTH-1:0]    hrdata_i,
  input  logic                     hreadyout_i,
  input  logic                     hresp_i
);

  ingress_state_e          state_q;
  htrans_e                 htrans_q;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic                    hwrite_q;
  logic [2:0]              hsize_q;
  logic                    hsel_q;
  logic [DATA_WIDTH-1:0]   hwdata_q;
  logic [STRB_WIDTH-1:0]   hwstrb_q;
  logic [XBAR_ID_WIDTH-1:0] cid_q;
  logic                    wcap_q;
  logic                    decHit;
  logic [XBAR_ID_WIDTH-1:0] decCid;
  logic                    accept;

  xbar_ahb_addr_dec #(
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_CID  (REGION_CID)
  ) u_dec (
    .addr_i (haddr_i),
    .hit_o  (decHit),
    .cid_o  (decCid)
  );

  assign accept = hsel_i && htrans_i[1] && hreadyout_o;

  // Single-outstanding transfer FSM; write data arrives in the manager data phase, i.e. the first ADDR cycle.
  always_ff @(posedge hclk_i or posedge hrst_i) begin
    if (hrst_i) begin
      state_q  <= ST_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hsel_q   <= 1'b0;
      hwdata_q <= '0;
      hwstrb_q <= '0;
      cid_q    <= '0;
      wcap_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
`ifdef XBAR_AHB_DECERR_EN
            if (!decHit) state_q <= ST_ERR1;
            else
`endif
            begin
              state_q  <= ST_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              haddr_q  <= haddr_i;
              hwrite_q <= hwrite_i;
              hsize_q  <= hsize_i;
              hsel_q   <= 1'b1;
              cid_q    <= decHit ? decCid : DEFAULT_CID;
              wcap_q   <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (wcap_q) begin
            hwdata_q <= hwdata_i;
            hwstrb_q <= hwstrb_i;
            wcap_q   <= 1'b0;
          end
          if (hreadyout_i) begin
            state_q  <= ST_DATA;
            htrans_q <= HTRANS_IDLE;
            hsel_q   <= 1'b0;
          end
        end
        ST_DATA: begin
          if (hreadyout_i) state_q <= ST_IDLE;
        end
`ifdef XBAR_AHB_DECERR_EN
        ST_ERR1: state_q <= ST_ERR2;
        ST_ERR2: state_q <= ST_IDLE;
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Manager-facing response: the node's data phase is passed straight through so its ERROR shape survives.
  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = 1'b0;
    hrdata_o    = '0;
    case (state_q)
      ST_ADDR: hreadyout_o = 1'b0;
      ST_DATA: begin
        hreadyout_o = hreadyout_i;
        hresp_o     = hresp_i;
        hrdata_o    = hrdata_i;
      end
`ifdef XBAR_AHB_DECERR_EN
      ST_ERR1: begin
        hreadyout_o = 1'b0;
        hresp_o     = 1'b1;
      end
      ST_ERR2: hresp_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign rid_o    = ROW_ID;
  assign cid_o    = cid_q;
  assign haddr_o  = haddr_q;
  assign htrans_o = htrans_q;
  assign hwrite_o = hwrite_q;
  assign hsize_o  = hsize_q;
  assign hsel_o   = hsel_q;
  assign hwdata_o = hwdata_q;
  assign hwstrb_o = hwstrb_q;

endmodule

// File: tb/tb_xbar_ahb_ingress.sv
// Self-checking bench for xbar_ahb_ingress: directed corner cases plus randomized transfers against a region-table model.
module tb_xbar_ahb_ingress;

   localparam logic [1:0] ROW_ID_P      = 2'd1;
   localparam logic [1:0] DEFAULT_CID_P = 2'd2;

   // Region table as the manager sees it: index 0 has priority.
   localparam logic [31:0] regBase [4] = '{32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
   localparam logic [31:0] regMask [4] = '{32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000, 32'hC000_0000};
   localparam logic [1:0]  regCid  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic        hsel;
   logic [31:0] hwdata;
   logic [3:0]  hwstrb;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;
   logic [1:0]  rid;
   logic [1:0]  cid;
   logic [31:0] reqAddr;
   logic [1:0]  reqTrans;
   logic        reqWrite;
   logic [2:0]  reqSize;
   logic        reqSel;
   logic [31:0] reqWdata;
   logic [3:0]  reqWstrb;
   logic [31:0] nodeRdata;
   logic        nodeReady;
   logic        nodeResp;

   int checkCount = 0;
   int passCount  = 0;

   xbar_ahb_ingress #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .XBAR_ID_WIDTH (2),
      .NUM_REGIONS   (4),
      .ROW_ID        (ROW_ID_P),
      .REGION_BASE   ({32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000}),
      .REGION_MASK   ({32'hC000_0000, 32'hF000_0000, 32'hFFFF_FF00, 32'hF000_0000}),
      .REGION_CID    ({2'd0, 2'd3, 2'd2, 2'd1}),
      .DEFAULT_CID   (DEFAULT_CID_P)
   ) dut (
      .hclk_i      (clock),
      .hrst_i      (reset),
      .haddr_i     (haddr),
      .htrans_i    (htrans),
      .hwrite_i    (hwrite),
      .hsize_i     (hsize),
      .hsel_i      (hsel),
      .hwdata_i    (hwdata),
      .hwstrb_i    (hwstrb),
      .hrdata_o    (hrdata),
      .hreadyout_o (hreadyout),
      .hresp_o     (hresp),
      .rid_o       (rid),
      .cid_o       (cid),
      .haddr_o     (reqAddr),
      .htrans_o    (reqTrans),
      .hwrite_o    (reqWrite),
      .hsize_o     (reqSize),
      .hsel_o      (reqSel),
      .hwdata_o    (reqWdata),
      .hwstrb_o    (reqWstrb),
      .hrdata_i    (nodeRdata),
      .hreadyout_i (nodeReady),
      .hresp_i     (nodeResp)
   );

   // Free-running 10-unit clock; the DUT acts on the rising edge.
   always #5 clock = ~clock;

   // Backstop so a broken DUT can never stall the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
   endtask

   // Reference decode straight from the region rules: first matching entry wins.
   function automatic void refDecode(input logic [31:0] addr, output logic hit, output logic [1:0] cidOut);
      hit = 1'b0;
      cidOut = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!hit && ((addr & regMask[i]) == (regBase[i] & regMask[i]))) begin
            hit = 1'b1;
            cidOut = regCid[i];
         end
      end
   endfunction

   task automatic driveIdle();
      hsel = 1'b0;
      htrans = 2'b00;
      haddr = 32'h0;
      hwrite = 1'b0;
      hsize = 3'd0;
   endtask

   // One full manager transfer, with node wait states in the address and data phases and an optional node ERROR.
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int addrWait, input int dataWaitIn,
                                input logic nodeErr, input logic [31:0] rdata);
      logic       hit;
      logic [1:0] expCid;
      logic       expErr;
      logic [2:0] sz;
      int         dataWait;
      logic [31:0] drvData;
      refDecode(addr, hit, expCid);
`ifdef XBAR_AHB_DECERR_EN
      expErr = !hit;
`else
      expErr = 1'b0;
      if (!hit) expCid = DEFAULT_CID_P;
`endif
      dataWait = (nodeErr && dataWaitIn == 0) ? 1 : dataWaitIn;
      sz = 3'($urandom_range(0, 2));

      @(posedge clock); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = sz;
      nodeReady = 1'b1; nodeResp = 1'b0; nodeRdata = $urandom;
      @(negedge clock);
      checkOutput("addr_phase_ready", 32'(hreadyout), 32'd1);

      @(posedge clock); #1;
      driveIdle();
      haddr = $urandom;
      hwdata = wdata; hwstrb = wstrb;
      if (expErr) begin
         @(negedge clock);
         checkOutput("err1_resp", 32'(hresp), 32'd1);
         checkOutput("err1_ready", 32'(hreadyout), 32'd0);
         checkOutput("err1_trans", 32'(reqTrans), 32'd0);
         checkOutput("err1_rdata", hrdata, 32'd0);
         @(posedge clock); #1;
         hwdata = $urandom;
         @(negedge clock);
         checkOutput("err2_resp", 32'(hresp), 32'd1);
         checkOutput("err2_ready", 32'(hreadyout), 32'd1);
         checkOutput("err2_trans", 32'(reqTrans), 32'd0);
      end else begin
         for (int i = 0; i <= addrWait; i++) begin
            if (i > 0) begin
               @(posedge clock); #1;
               hwdata = $urandom; hwstrb = 4'($urandom);
            end
            nodeReady = (i == addrWait);
            @(negedge clock);
            checkOutput("req_trans", 32'(reqTrans), 32'h2);
            checkOutput("req_sel", 32'(reqSel), 32'd1);
            checkOutput("req_addr", reqAddr, addr);
            checkOutput("req_write", 32'(reqWrite), 32'(wr));
            checkOutput("req_size", 32'(reqSize), 32'(sz));
            checkOutput("req_cid", 32'(cid), 32'(expCid));
            checkOutput("req_rid", 32'(rid), 32'(ROW_ID_P));
            checkOutput("addr_wait_ready", 32'(hreadyout), 32'd0);
            if (i > 0) checkOutput("wdata_held_addr", reqWdata, wdata);
         end
         for (int i = 0; i <= dataWait; i++) begin
            @(posedge clock); #1;
            nodeReady = (i == dataWait);
            nodeResp = nodeErr && (i >= dataWait - 1);
            drvData = (i == dataWait) ? rdata : $urandom;
            nodeRdata = drvData;
            hwdata = $urandom;
            @(negedge clock);
            checkOutput("data_trans", 32'(reqTrans), 32'd0);
            checkOutput("data_ready", 32'(hreadyout), 32'(i == dataWait));
            checkOutput("data_resp", 32'(hresp), 32'(nodeErr && (i >= dataWait - 1)));
            checkOutput("data_rdata", hrdata, drvData);
            checkOutput("data_wdata", reqWdata, wdata);
            checkOutput("data_wstrb", 32'(reqWstrb), 32'(wstrb));
         end
      end

      @(posedge clock); #1;
      nodeReady = 1'b1; nodeResp = 1'b0; nodeRdata = $urandom;
      @(negedge clock);
      checkOutput("back_idle_ready", 32'(hreadyout), 32'd1);
      checkOutput("back_idle_resp", 32'(hresp), 32'd0);
      checkOutput("back_idle_trans", 32'(reqTrans), 32'd0);
      checkOutput("back_idle_rdata", hrdata, 32'd0);
   endtask

   // A non-transfer address phase: nothing may be issued and the manager sees zero-wait OKAY.
   task automatic applyNoTransfer(input logic selIn, input logic [1:0] transIn);
      @(posedge clock); #1;
      hsel = selIn; htrans = transIn; haddr = 32'h0000_0010; hwrite = 1'b0;
      @(negedge clock);
      checkOutput("notx_ready", 32'(hreadyout), 32'd1);
      @(posedge clock); #1;
      driveIdle();
      @(negedge clock);
      checkOutput("notx_ready_next", 32'(hreadyout), 32'd1);
      checkOutput("notx_resp", 32'(hresp), 32'd0);
      checkOutput("notx_trans", 32'(reqTrans), 32'd0);
      checkOutput("notx_sel", 32'(reqSel), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      driveIdle();
      hwdata = 32'h0; hwstrb = 4'h0;
      nodeRdata = 32'hDEAD_BEEF; nodeReady = 1'b1; nodeResp = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_ready", 32'(hreadyout), 32'd1);
      checkOutput("rst_resp", 32'(hresp), 32'd0);
      checkOutput("rst_rdata", hrdata, 32'd0);
      checkOutput("rst_trans", 32'(reqTrans), 32'd0);
      checkOutput("rst_sel", 32'(reqSel), 32'd0);
      checkOutput("rst_addr", reqAddr, 32'd0);
      checkOutput("rst_cid", 32'(cid), 32'd0);
      checkOutput("rst_rid", 32'(rid), 32'(ROW_ID_P));
      @(posedge clock); #1;
      reset = 1'b0;

      $display("[TB] directed transfers");
      applyStimulus(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFE_F00D);
      applyStimulus(32'h0000_0020, 1'b1, 32'h1234_5678, 4'hF, 0, 2, 1'b0, 32'h0);
      applyStimulus(32'h0000_0040, 1'b0, 32'h0, 4'h0, 1, 0, 1'b0, 32'h5555_AAAA);
      applyStimulus(32'hF000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0BAD_0BAD);
      applyStimulus(32'h4000_0100, 1'b1, 32'hA5A5_5A5A, 4'h3, 0, 1, 1'b1, 32'h0);
      applyNoTransfer(1'b1, 2'b01);
      applyNoTransfer(1'b0, 2'b10);

      $display("[TB] reset during address phase");
      @(posedge clock); #1;
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0010; hwrite = 1'b0;
      @(posedge clock); #1;
      driveIdle();
      nodeReady = 1'b0;
      @(negedge clock);
      checkOutput("mid_rst_pre_trans", 32'(reqTrans), 32'h2);
      #2 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      nodeReady = 1'b1;
      @(negedge clock);
      checkOutput("mid_rst_trans", 32'(reqTrans), 32'd0);
      checkOutput("mid_rst_ready", 32'(hreadyout), 32'd1);
      checkOutput("mid_rst_cid", 32'(cid), 32'd0);
      checkOutput("mid_rst_sel", 32'(reqSel), 32'd0);

      $display("[TB] randomized transfers");
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = {4'($urandom), 28'($urandom_range(0, 511))};
         applyStimulus(a, 1'($urandom), $urandom, 4'($urandom),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
